// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline constants: forward-source encodings, op result latencies
// and the default back-end depth.
package dlx_pipe_pkg;

    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    localparam int DEPTH_DEFAULT = 3;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-write flag, producer age and forwardable age
// for a single architectural register.
module sb_entry
    import dlx_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fire,
    input  logic          flush,
    input  logic [AW-1:0] lat,
    output logic          busy,
    output logic [AW-1:0] age,
    output logic [AW-1:0] rdy
);

    // A new issue beats both the age-out and the flush of an older producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            age  <= '0;
            rdy  <= '0;
        end else if (fire) begin
            busy <= 1'b1;
            age  <= AW'(1);
            rdy  <= lat;
        end else if (busy) begin
            if ((age == AW'(DEPTH)) || (flush && (age == AW'(1)))) begin
                busy <= 1'b0;
                age  <= '0;
                rdy  <= '0;
            end else begin
                age <= age + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dlx_hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the DLX pipeline: per-register pending-write
// tracking, ID-stage stall, per-port forward select and a saturating stall counter.
module dlx_hazard_scoreboard
    import dlx_pipe_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int RW     = 5,
    parameter int NPORTS = 2,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int AW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [RW-1:0]        issue_rd,
    input  logic [AW-1:0]        issue_lat,
    input  logic                 flush,
    input  logic [NPORTS*RW-1:0] rs_sel,
    input  logic [NPORTS-1:0]    rs_used,
    output logic                 stall,
    output logic [NPORTS*AW-1:0] fwd_sel,
    output logic [NREGS-1:0]     busy,
    output logic [31:0]          stall_cnt
);

    logic [NREGS-1:0] busy_vec;
    logic [AW-1:0]    age_arr [NREGS];
    logic [AW-1:0]    rdy_arr [NREGS];
    logic [AW-1:0]    lat_c;
    logic             fire;
    logic             stall_int;
    logic [31:0]      stall_cnt_q;
    logic [RW-1:0]    rs_idx  [NPORTS];
    logic             hit     [NPORTS];

    always_comb begin
        if (issue_lat == '0)
            lat_c = AW'(LAT_ALU);
        else if (issue_lat > AW'(DEPTH))
            lat_c = AW'(DEPTH);
        else
            lat_c = issue_lat;
    end

    assign fire = issue_valid && issue_we && !stall_int && !flush && (issue_rd != '0);

    // R0 never holds a pending write.
    assign busy_vec[0] = 1'b0;
    assign age_arr[0]  = '0;
    assign rdy_arr[0]  = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        sb_entry #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .fire  (fire && (issue_rd == RW'(r))),
            .flush (flush),
            .lat   (lat_c),
            .busy  (busy_vec[r]),
            .age   (age_arr[r]),
            .rdy   (rdy_arr[r])
        );
    end

    always_comb begin
        stall_int = 1'b0;
        fwd_sel   = '0;
        rs_idx    = '{default: '0};
        hit       = '{default: 1'b0};
        for (int p = 0; p < NPORTS; p++) begin
            rs_idx[p] = rs_sel[p*RW +: RW];
            hit[p]    = rs_used[p] && (rs_idx[p] != '0) && busy_vec[rs_idx[p]];
            if (hit[p] && (age_arr[rs_idx[p]] < rdy_arr[rs_idx[p]]))
                stall_int = 1'b1;
            fwd_sel[p*AW +: AW] = (hit[p] && (age_arr[rs_idx[p]] >= rdy_arr[rs_idx[p]]))
                                  ? age_arr[rs_idx[p]] : AW'(FWD_RF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall     = stall_int;
    assign busy      = busy_vec;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dlx_hazard_scoreboard.sv
// Directed bench for dlx_hazard_scoreboard: RAW forwarding, load-use stall,
// youngest-producer, flush, R0/unused ports, saturation and async reset.
module tb_dlx_hazard_scoreboard;

    localparam int NREGS  = 32;
    localparam int RW     = 5;
    localparam int NPORTS = 2;
    localparam int DEPTH  = 3;
    localparam int AW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic                 issue_we;
    logic [RW-1:0]        issue_rd;
    logic [AW-1:0]        issue_lat;
    logic                 flush;
    logic [NPORTS*RW-1:0] rs_sel;
    logic [NPORTS-1:0]    rs_used;
    logic                 stall;
    logic [NPORTS*AW-1:0] fwd_sel;
    logic [NREGS-1:0]     busy;
    logic [31:0]          stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dlx_hazard_scoreboard #(
        .NREGS  (NREGS),
        .RW     (RW),
        .NPORTS (NPORTS),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .rs_sel      (rs_sel),
        .rs_used     (rs_used),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        flush       = 1'b0;
        rs_sel      = '0;
        rs_used     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = RW'(rd);
        issue_lat   = AW'(lat);
    endtask

    task automatic set_rs(input int p, input int r, input bit used);
        rs_sel[p*RW +: RW] = RW'(r);
        rs_used[p]         = used;
    endtask

    function automatic logic [AW-1:0] fwd(input int p);
        return fwd_sel[p*AW +: AW];
    endfunction

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_busy", busy, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_fwd", {28'b0, fwd_sel}, 32'h0);
        check("rst_cnt", stall_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU RAW: forward from EX, MEM, WB, then register file
        issue(3, 1);
        step();
        idle();
        set_rs(0, 3, 1'b1);
        #1;
        check("alu_c1_stall", {31'b0, stall}, 32'h0);
        check("alu_c1_fwd", {30'b0, fwd(0)}, 32'd1);
        step();
        check("alu_c2_fwd", {30'b0, fwd(0)}, 32'd2);
        step();
        check("alu_c3_fwd", {30'b0, fwd(0)}, 32'd3);
        step();
        check("alu_c4_fwd", {30'b0, fwd(0)}, 32'd0);
        check("alu_c4_busy", {31'b0, busy[3]}, 32'h0);
        drain();

        // Load-use: one stall, the stalled instruction must not create an entry
        issue(4, 2);
        step();
        idle();
        set_rs(1, 4, 1'b1);
        issue(8, 1);
        #1;
        check("ld_c1_stall", {31'b0, stall}, 32'h1);
        check("ld_c1_fwd", {30'b0, fwd(1)}, 32'd0);
        step();
        idle();
        set_rs(1, 4, 1'b1);
        #1;
        check("ld_c2_stall", {31'b0, stall}, 32'h0);
        check("ld_c2_fwd", {30'b0, fwd(1)}, 32'd2);
        check("ld_c2_cnt", stall_cnt, 32'd1);
        check("ld_no_fire_r8", {31'b0, busy[8]}, 32'h0);
        drain();

        // Youngest producer wins
        issue(5, 1);
        step();
        step();
        idle();
        set_rs(0, 5, 1'b1);
        #1;
        check("yw_c2_fwd", {30'b0, fwd(0)}, 32'd1);
        step();
        step();
        check("yw_c4_busy", {31'b0, busy[5]}, 32'h1);
        step();
        check("yw_c5_busy", {31'b0, busy[5]}, 32'h0);
        drain();

        // Flush kills the EX producer and blocks the ID issue
        issue(6, 2);
        step();
        issue(7, 1);
        flush = 1'b1;
        #1;
        check("fl_c1_busy6", {31'b0, busy[6]}, 32'h1);
        step();
        idle();
        set_rs(0, 6, 1'b1);
        #1;
        check("fl_c2_busy6", {31'b0, busy[6]}, 32'h0);
        check("fl_c2_busy7", {31'b0, busy[7]}, 32'h0);
        check("fl_c2_stall", {31'b0, stall}, 32'h0);
        drain();

        // R0 writes ignored, unused ports and rs=0 read the RF, lat 0 acts as 1
        issue(0, 1);
        step();
        check("r0_busy", busy, 32'h0);
        issue(11, 0);
        step();
        idle();
        set_rs(0, 11, 1'b1);
        set_rs(1, 11, 1'b0);
        #1;
        check("lat0_stall", {31'b0, stall}, 32'h0);
        check("lat0_fwd0", {30'b0, fwd(0)}, 32'd1);
        check("unused_fwd1", {30'b0, fwd(1)}, 32'd0);
        step();
        set_rs(0, 0, 1'b1);
        set_rs(1, 11, 1'b1);
        #1;
        check("rs0_fwd0", {30'b0, fwd(0)}, 32'd0);
        check("used_fwd1", {30'b0, fwd(1)}, 32'd2);
        drain();

        // Saturation: preload the counter near its limit during a 2-cycle stall
        issue(10, 3);
        step();
        idle();
        set_rs(0, 10, 1'b1);
        #1;
        check("sat_c1_stall", {31'b0, stall}, 32'h1);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        step();
        check("sat_c2_stall", {31'b0, stall}, 32'h1);
        check("sat_c2_cnt", stall_cnt, 32'hFFFF_FFFF);
        step();
        check("sat_c3_cnt", stall_cnt, 32'hFFFF_FFFF);
        check("sat_c3_fwd", {30'b0, fwd(0)}, 32'd3);
        drain();

        // Async reset with r9 at age 2 (stalling) and r2 at age 1
        issue(9, 3);
        step();
        issue(2, 1);
        step();
        idle();
        set_rs(0, 2, 1'b1);
        set_rs(1, 9, 1'b1);
        #1;
        check("ar_pre_stall", {31'b0, stall}, 32'h1);
        check("ar_pre_busy", busy, 32'h0000_0204);
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 32'h0);
        check("ar_stall", {31'b0, stall}, 32'h0);
        check("ar_fwd", {28'b0, fwd_sel}, 32'h0);
        check("ar_cnt", stall_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
